// File: rtl/otp_pad_controller.sv
// One-time-pad encrypt/decrypt controller: 8-slot pad store, round-robin
// arbitration between encrypt and decrypt requesters, 2-cycle result latency.
module otp_pad_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] prn,
  input  logic       enc_req,
  input  logic [7:0] enc_data,
  input  logic       dec_req,
  input  logic [2:0] dec_idx,
  input  logic [7:0] dec_data,
  input  logic       flush,
  output logic       enc_ack,
  output logic       dec_ack,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [2:0] out_idx,
  output logic       out_err,
  output logic [7:0] valid_map,
  output logic [3:0] used,
  output logic       full,
  output logic       empty
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic       is_enc;
    logic [2:0] idx;
    logic [7:0] data;
  } op_t;

  state_t          state, state_nxt;
  op_t             op;
  logic [7:0][7:0] pad;
  logic            last_dec;
  logic            grant_enc, grant_dec, do_flush;
  logic [2:0]      free_slot;
  logic [7:0]      vmap_nxt;
  logic [3:0]      used_nxt;

  // Encrypt is only eligible while a free slot exists; ties go to whoever lost last.
  always_comb begin
    state_nxt = state;
    grant_enc = 1'b0;
    grant_dec = 1'b0;
    do_flush  = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          if (flush)                     do_flush  = 1'b1;
          else if (enc_req && !full && dec_req) begin
            if (last_dec)                grant_enc = 1'b1;
            else                         grant_dec = 1'b1;
          end
          else if (enc_req && !full)     grant_enc = 1'b1;
          else if (dec_req)              grant_dec = 1'b1;
        end
        if (grant_enc || grant_dec) state_nxt = BUSY;
      end
      BUSY:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    free_slot = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (!valid_map[i]) free_slot = 3'(i);
  end

  always_comb begin
    vmap_nxt = valid_map;
    if (do_flush)
      vmap_nxt = '0;
    else if (state == BUSY) begin
      if (op.is_enc) vmap_nxt[op.idx] = 1'b1;
      else           vmap_nxt[op.idx] = 1'b0;
    end
    used_nxt = '0;
    for (int i = 0; i < 8; i++)
      used_nxt = used_nxt + {3'd0, vmap_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= '0;
      pad       <= '0;
      last_dec  <= 1'b1;
      enc_ack   <= 1'b0;
      dec_ack   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
      valid_map <= '0;
      used      <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      state     <= state_nxt;
      enc_ack   <= grant_enc;
      dec_ack   <= grant_dec;
      out_valid <= 1'b0;
      valid_map <= vmap_nxt;
      used      <= used_nxt;
      full      <= (used_nxt == 4'd8);
      empty     <= (used_nxt == 4'd0);
      if (grant_enc || grant_dec) begin
        op.is_enc <= grant_enc;
        op.idx    <= grant_enc ? free_slot : dec_idx;
        op.data   <= grant_enc ? enc_data  : dec_data;
        last_dec  <= grant_dec;
      end
      if (do_flush) pad <= '0;
      if (state == BUSY) begin
        out_valid <= 1'b1;
        out_idx   <= op.idx;
        if (op.is_enc) begin
          pad[op.idx] <= prn;
          out_data    <= op.data ^ prn;
          out_err     <= 1'b0;
        end else if (valid_map[op.idx]) begin
          out_data    <= op.data ^ pad[op.idx];
          out_err     <= 1'b0;
          pad[op.idx] <= '0;
        end else begin
          out_data    <= '0;
          out_err     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_otp_pad_controller.sv
// Scoreboarded bench for otp_pad_controller: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_otp_pad_controller;
  logic       clk = 0;
  logic       rst_n, ena, enc_req, dec_req, flush;
  logic [7:0] prn, enc_data, dec_data;
  logic [2:0] dec_idx;
  logic       enc_ack, dec_ack, out_valid, out_err, full, empty;
  logic [7:0] out_data, valid_map;
  logic [2:0] out_idx;
  logic [3:0] used;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];   // {data, idx, err}

  otp_pad_controller dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .prn(prn),
    .enc_req(enc_req), .enc_data(enc_data),
    .dec_req(dec_req), .dec_idx(dec_idx), .dec_data(dec_data),
    .flush(flush), .enc_ack(enc_ack), .dec_ack(dec_ack),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_err(out_err),
    .valid_map(valid_map), .used(used), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got data=0x%0h idx=%0d err=%0b expected none",
                 out_data, out_idx, out_err);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e[11:4]});
        chk("out_idx",  {29'd0, out_idx},  {29'd0, e[3:1]});
        chk("out_err",  {31'd0, out_err},  {31'd0, e[0]});
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input bit is_enc, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (is_enc ? enc_ack : dec_ack) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_ack_timeout: got no ack expected ack", is_enc ? "enc" : "dec");
    end
  endtask

  task automatic do_enc(input logic [7:0] d, input logic [7:0] p, input logic [2:0] slot);
    bit ok;
    prn = p; enc_data = d; enc_req = 1;
    wait_ack(1, ok);
    enc_req = 0;
    if (ok) exp_q.push_back({d ^ p, slot, 1'b0});
    tick();
    chk("enc_ack_pulse", {31'd0, enc_ack}, 32'd0);
  endtask

  task automatic do_dec(input logic [2:0] idx, input logic [7:0] d,
                        input logic [7:0] exp_d, input logic exp_e);
    bit ok;
    dec_idx = idx; dec_data = d; dec_req = 1;
    wait_ack(0, ok);
    dec_req = 0;
    if (ok) exp_q.push_back({exp_d, idx, exp_e});
    tick();
  endtask

  initial begin
    bit ok;
    int last_t, t;
    bit want_enc;
    int enc_cnt;
    rst_n = 0; ena = 1; enc_req = 0; dec_req = 0; flush = 0;
    prn = 0; enc_data = 0; dec_data = 0; dec_idx = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("rst_valid_map", {24'd0, valid_map}, 32'd0);
    chk("rst_used",      {28'd0, used},      32'd0);
    chk("rst_empty",     {31'd0, empty},     32'd1);
    chk("rst_full",      {31'd0, full},      32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_acks",      {30'd0, enc_ack, dec_ack}, 32'd0);

    // Basic encrypt then decrypt of slot 0, then repeat decrypt on an empty slot
    do_enc(8'h3C, 8'hA5, 3'd0);
    chk("vmap_after_enc", {24'd0, valid_map}, 32'h01);
    tick();
    chk("hold_out_data", {24'd0, out_data},  32'h99);
    chk("hold_out_vld",  {31'd0, out_valid}, 32'd0);
    do_dec(3'd0, 8'h99, 8'h3C, 1'b0);
    chk("vmap_after_dec", {24'd0, valid_map}, 32'h00);
    do_dec(3'd0, 8'h99, 8'h00, 1'b1);

    // Fill all eight slots: slot i gets pad 0x10+i, plaintext i*0x11
    for (int i = 0; i < 8; i++)
      do_enc(8'(i * 8'h11), 8'(8'h10 + i), 3'(i));
    chk("fill_vmap", {24'd0, valid_map}, 32'hFF);
    chk("fill_used", {28'd0, used},      32'd8);
    chk("fill_full", {31'd0, full},      32'd1);

    // Ninth encrypt stalls until slot 3 is decrypted, then lands in slot 3
    enc_req = 1; enc_data = 8'h5A; prn = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_blocks_enc", {31'd0, enc_ack}, 32'd0);
    end
    dec_idx = 3'd3; dec_data = 8'h20; dec_req = 1;
    wait_ack(0, ok);
    dec_req = 0;
    if (ok) exp_q.push_back({8'h33, 3'd3, 1'b0});
    wait_ack(1, ok);
    enc_req = 0;
    if (ok) exp_q.push_back({8'h55, 3'd3, 1'b0});
    tick();
    chk("refill_vmap", {24'd0, valid_map}, 32'hFF);

    // Empty slots 0..3 so valid_map = 0xF0
    do_dec(3'd0, 8'h10, 8'h00, 1'b0);
    do_dec(3'd1, 8'h00, 8'h11, 1'b0);
    do_dec(3'd2, 8'h30, 8'h22, 1'b0);
    do_dec(3'd3, 8'h55, 8'h5A, 1'b0);
    chk("vmap_f0", {24'd0, valid_map}, 32'hF0);
    chk("used_4",  {28'd0, used},      32'd4);

    // Flush is ignored while ena=0, honoured with ena=1
    ena = 0; flush = 1;
    repeat (3) tick();
    chk("flush_dis_vmap", {24'd0, valid_map}, 32'hF0);
    ena = 1;
    tick();
    flush = 0;
    chk("flush_vmap",  {24'd0, valid_map}, 32'h00);
    chk("flush_empty", {31'd0, empty},     32'd1);
    chk("flush_used",  {28'd0, used},      32'd0);
    chk("flush_noack", {30'd0, enc_ack, dec_ack}, 32'd0);
    tick();

    // Contending requesters alternate enc/dec, 2 cycles apart (last grant was dec)
    enc_req = 1; enc_data = 8'h01; prn = 8'h80;
    dec_req = 1; dec_idx = 3'd5; dec_data = 8'h77;
    want_enc = 1; enc_cnt = 0; last_t = 0; t = 0;
    for (int k = 0; k < 6; k++) begin
      ok = 0;
      for (int i = 0; i < 6; i++) begin
        tick(); t++;
        if (enc_ack || dec_ack) begin ok = 1; break; end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL rr_timeout: got no ack expected ack %0d", k);
        break;
      end
      chk("rr_enc_ack", {31'd0, enc_ack}, {31'd0, want_enc});
      chk("rr_dec_ack", {31'd0, dec_ack}, {31'd0, !want_enc});
      if (k > 0) chk("rr_spacing", t - last_t, 32'd2);
      last_t = t;
      if (enc_ack) begin
        exp_q.push_back({8'h81, 3'(enc_cnt), 1'b0});
        enc_cnt++;
      end else if (dec_ack)
        exp_q.push_back({8'h00, 3'd5, 1'b1});
      want_enc = !want_enc;
    end
    enc_req = 0; dec_req = 0;
    repeat (3) tick();
    chk("rr_vmap", {24'd0, valid_map}, 32'h07);

    // Reset during BUSY of an encrypt aborts it
    enc_req = 1; enc_data = 8'hC3; prn = 8'h3C;
    wait_ack(1, ok);
    rst_n = 0; enc_req = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("abort_vmap",  {24'd0, valid_map}, 32'd0);
    chk("abort_used",  {28'd0, used},      32'd0);
    chk("abort_empty", {31'd0, empty},     32'd1);
    chk("abort_full",  {31'd0, full},      32'd0);
    chk("abort_outs",  {19'd0, out_valid, out_data, out_idx, out_err}, 32'd0);
    chk("abort_acks",  {30'd0, enc_ack, dec_ack}, 32'd0);
    repeat (2) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/otp_pad_controller.md
OTP_PAD_CONTROLLER -- requirements
Module: otp_pad_controller

Interface
REQ-001 SHALL have clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-003 SHALL have ena, input, 1, high permits new grants; in-flight operation completes regardless.
REQ-004 SHALL have prn, input, 8, pseudo-random pad byte from the LFSR, sampled only in BUSY.
REQ-005 SHALL have enc_req, input, 1, plus enc_data, input, 8: encrypt requester, held until enc_ack.
REQ-006 SHALL have dec_req, input, 1, dec_idx, input, 3, and dec_data, input, 8: decrypt requester, held until dec_ack.
REQ-007 SHALL have flush, input, 1, request to erase all pads.
REQ-008 SHALL have enc_ack and dec_ack, output, 1 each: one-cycle registered grant pulses.
REQ-009 SHALL have out_valid, output, 1; out_data, output, 8; out_idx, output, 3; out_err, output, 1: result bus, valid one cycle.
REQ-010 SHALL have valid_map, output, 8; used, output, 4; full, output, 1; empty, output, 1: slot status.

Function
REQ-011 SHALL keep an internal 8x8 pad store and an 8-bit valid_map, bit i set when slot i holds an unconsumed pad.
REQ-012 SHALL implement FSM states IDLE and BUSY; a grant moves IDLE->BUSY; BUSY always returns to IDLE after one cycle.
REQ-013 In IDLE with ena=1: flush has top priority; it zeroes the pad store and valid_map at that edge, issues no ack and no out_valid, and the FSM stays in IDLE.
REQ-014 Encrypt SHALL be eligible only when full=0; decrypt SHALL always be eligible.
REQ-015 When both are eligible in the same cycle, grant SHALL alternate round-robin using a last_grant bit; after reset encrypt wins first.
REQ-016 On grant at the edge ending cycle N, the controller SHALL capture data/index, pulse the matching ack during cycle N+1, and be in BUSY during cycle N+1.
REQ-017 Encrypt allocation SHALL select the lowest-numbered slot with valid_map bit 0, captured at grant.
REQ-018 BUSY encrypt SHALL write prn into the slot, set its valid bit, and register out_data=enc_data^prn, out_idx=slot, out_err=0.
REQ-019 BUSY decrypt with a valid slot SHALL register out_data=dec_data^pad[idx], out_idx=idx, out_err=0, then clear that valid bit and zero that pad.
REQ-020 BUSY decrypt with an invalid slot SHALL register out_data=0, out_idx=idx, out_err=1, and leave the store unchanged.
REQ-021 out_valid SHALL be high in cycle N+2 only; latency from request sampling to result is 2 cycles; maximum throughput is one operation per 2 cycles.
REQ-022 out_data, out_idx and out_err SHALL hold their last values while out_valid=0.
REQ-023 used SHALL equal popcount(valid_map) (0..8); full=(used==8); empty=(used==0); all three SHALL be registered and consistent with valid_map.
REQ-024 ena=0 in IDLE SHALL block grants and flush; ena=0 during BUSY SHALL NOT abort the operation.
REQ-025 A request deasserted before its ack SHALL be dropped with no side effect.

Reset
REQ-026 rst_n=0 SHALL force IDLE, zero the pad store, valid_map, used, all acks, and out_valid/out_data/out_idx/out_err; it SHALL also set empty=1, full=0, and last_grant=decrypt.
REQ-027 Reset asserted during BUSY SHALL abort the operation: no out_valid, and no store update.

Verification
REQ-028 After reset, encrypt enc_data=0x3C with prn=0xA5 -> enc_ack in N+1; out_valid in N+2 with out_data=0x99, out_idx=0, out_err=0; valid_map=0x01.
REQ-029 Then decrypt dec_idx=0, dec_data=0x99 -> out_data=0x3C, out_err=0, valid_map=0x00; repeat the same decrypt -> out_err=1, out_data=0x00.
REQ-030 Perform eight encrypts -> slots 0..7 used in order, full=1, used=8; a ninth enc_req receives no ack until a decrypt of slot 3 completes, then the ninth encrypt is allocated slot 3.
REQ-031 Hold enc_req and dec_req together continuously -> acks alternate enc, dec, enc, dec..., each one cycle, spaced 2 cycles apart.
REQ-032 With valid_map=0xF0, assert flush with ena=1 -> valid_map=0x00 and empty=1, with no ack and no out_valid; the same stimulus with ena=0 -> no change.
REQ-033 Assert rst_n=0 during BUSY of an encrypt -> no out_valid, and valid_map, used and all outputs equal 0.
